// File: rtl/dds_wavegen_if.sv
// Configuration port for dds_wavegen: valid/ready offer of frequency word, waveform select and duty.
interface dds_wavegen_if #(
  parameter int ACC_W = 32,
  parameter int OUT_W = 8
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [ACC_W-1:0] freq_word;
  logic [1:0]       wave_sel;
  logic [OUT_W-1:0] duty;

  modport master (output cfg_valid, freq_word, wave_sel, duty, input cfg_ready);
  modport slave  (input cfg_valid, freq_word, wave_sel, duty, output cfg_ready);
endinterface

// File: rtl/dds_wavegen.sv
// DDS waveform generator: phase accumulator shaped into saw / revsaw / triangle / square.
// Define DDS_PHASE_SYNC_EN to defer configuration updates to the next accumulator carry.
module dds_wavegen #(
  parameter int ACC_W = 32,
  parameter int OUT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  dds_wavegen_if.slave     cfg,
  output logic [ACC_W-1:0] phase,
  output logic [OUT_W-1:0] wave,
  output logic             wrap
);

  logic [ACC_W-1:0] acc, inc;
  logic [1:0]       sel;
  logic [OUT_W-1:0] dty;
  logic [ACC_W:0]   sum;
  logic             carry;
  logic [OUT_W-1:0] p, q, wave_nx;

  logic             load;
  logic [ACC_W-1:0] ld_inc;
  logic [1:0]       ld_sel;
  logic [OUT_W-1:0] ld_dty;

  assign sum   = {1'b0, acc} + {1'b0, inc};
  assign carry = enable & sum[ACC_W];
  assign p     = acc[ACC_W-1 -: OUT_W];
  assign q     = {p[OUT_W-2:0], 1'b0};
  assign phase = acc;

  always_comb begin
    wave_nx = p;
    case (sel)
      2'd0:    wave_nx = p;
      2'd1:    wave_nx = ~p;
      2'd2:    wave_nx = p[OUT_W-1] ? ~q : q;
      default: wave_nx = {OUT_W{p < dty}};
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc  <= '0;
      inc  <= '0;
      sel  <= '0;
      dty  <= {1'b1, {(OUT_W-1){1'b0}}};
      wave <= '0;
      wrap <= 1'b0;
    end else begin
      if (enable)
        acc <= sum[ACC_W-1:0];
      wrap <= carry;
      wave <= wave_nx;
      if (load) begin
        inc <= ld_inc;
        sel <= ld_sel;
        dty <= ld_dty;
      end
    end
  end

`ifdef DDS_PHASE_SYNC_EN
  typedef enum logic {IDLE, PEND} state_t;

  state_t           state, state_nx;
  logic [ACC_W-1:0] pnd_inc;
  logic [1:0]       pnd_sel;
  logic [OUT_W-1:0] pnd_dty;

  assign cfg.cfg_ready = (state == IDLE);
  assign ld_inc        = pnd_inc;
  assign ld_sel        = pnd_sel;
  assign ld_dty        = pnd_dty;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      pnd_inc <= '0;
      pnd_sel <= '0;
      pnd_dty <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && cfg.cfg_valid) begin
        pnd_inc <= cfg.freq_word;
        pnd_sel <= cfg.wave_sel;
        pnd_dty <= cfg.duty;
      end
    end
  end

  // A stalled or zero-step accumulator never carries, so release the buffer at once.
  always_comb begin
    state_nx = state;
    load     = 1'b0;
    case (state)
      IDLE: if (cfg.cfg_valid) state_nx = PEND;
      PEND: if (carry || !enable || inc == '0) begin
        state_nx = IDLE;
        load     = 1'b1;
      end
      default: state_nx = IDLE;
    endcase
  end
`else
  assign cfg.cfg_ready = 1'b1;
  assign load          = cfg.cfg_valid;
  assign ld_inc        = cfg.freq_word;
  assign ld_sel        = cfg.wave_sel;
  assign ld_dty        = cfg.duty;
`endif

endmodule
